// File: rtl/if_fetch_stage_pkg.sv
// Shared core constants and opcode encodings used by the fetch stage.
package if_fetch_stage_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_EXEC,
        REDIR_JAL
    } redir_src_e;

    function automatic logic is_jal(input logic [6:0] opcode);
        return opcode == OPC_JAL;
    endfunction

endpackage

// File: rtl/if_fetch_stage_fifo2.sv
// if_fifo2: two-entry {pc, inst} buffer between IMEM response and decode.
module if_fifo2
    import if_fetch_stage_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_pc,
    input  logic [WIDTH-1:0] push_inst,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_pc,
    output logic [WIDTH-1:0] head_inst,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] pc_mem   [2];
    logic [WIDTH-1:0] inst_mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is only legal when the head leaves on the same edge.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    assign head_valid = (count_q != 2'd0);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_inst  = inst_mem[rd_ptr];
    assign count      = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count_q     <= 2'd0;
            pc_mem[0]   <= '0;
            pc_mem[1]   <= '0;
            inst_mem[0] <= '0;
            inst_mem[1] <= '0;
        end else if (flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) begin
                pc_mem[wr_ptr]   <= push_pc;
                inst_mem[wr_ptr] <= push_inst;
                wr_ptr           <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction fetch stage: PC tracking, IMEM issue, 2-deep buffer, redirect squash.
// Optional JAL predecode redirect enabled by defining IF_JAL_PREDECODE_EN.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_en,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_inst
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));
    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] resp_pc_q;
    logic             inflight_q;
    logic             stale_q;

    logic             head_valid;
    logic [WIDTH-1:0] head_pc;
    logic [WIDTH-1:0] head_inst;
    logic [1:0]       fifo_count;

    logic [WIDTH-1:0] redirect_base;
    logic             pending;
    logic             push;
    logic             pop;
    logic [2:0]       occupancy;
    logic             jal_hit;
    logic [WIDTH-1:0] jal_target;
    redir_src_e       redir_src;

    assign redirect_base = redirect_pc & ALIGN_MASK;

    // A response arriving under an execute redirect belongs to the wrong path.
    assign pending = inflight_q && !stale_q;
    assign push    = pending && !redirect_valid;
    assign pop     = head_valid && out_ready && !redirect_valid;

    // Reserve a slot for every response that will land before the next issue returns.
    assign occupancy = {1'b0, fifo_count} + {2'b00, pending} - {2'b00, pop};

    assign imem_en   = rst_n && (redirect_valid || (occupancy < 3'd2));
    assign imem_addr = redirect_valid ? redirect_base : pc_q;

`ifdef IF_JAL_PREDECODE_EN
    logic [WIDTH-1:0] jal_imm;

    assign jal_imm    = {{(WIDTH-20){imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                         imem_rdata[30:21], 1'b0};
    assign jal_hit    = push && is_jal(imem_rdata[6:0]);
    assign jal_target = resp_pc_q + jal_imm;
`else
    assign jal_hit    = 1'b0;
    assign jal_target = pc_q;
`endif

    always_comb begin
        redir_src = REDIR_NONE;
        if (redirect_valid) begin
            redir_src = REDIR_EXEC;
        end else if (jal_hit) begin
            redir_src = REDIR_JAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            inflight_q <= imem_en;
            resp_pc_q  <= imem_addr;
            unique case (redir_src)
                REDIR_EXEC: begin
                    pc_q    <= redirect_base + PC_STEP;
                    stale_q <= 1'b0;
                end
                REDIR_JAL: begin
                    // The sequential word issued alongside the JAL is now wrong-path.
                    pc_q    <= jal_target;
                    stale_q <= imem_en;
                end
                default: begin
                    if (imem_en) begin
                        pc_q <= pc_q + PC_STEP;
                    end
                    stale_q <= 1'b0;
                end
            endcase
        end
    end

    if_fifo2 #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_pc   (resp_pc_q),
        .push_inst (imem_rdata),
        .pop       (pop),
        .head_valid(head_valid),
        .head_pc   (head_pc),
        .head_inst (head_inst),
        .count     (fifo_count)
    );

    assign out_valid = head_valid;
    assign out_pc    = head_valid ? head_pc : '0;
    assign out_inst  = head_valid ? head_inst : WIDTH'(INST_NOP);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: IMEM returns its own address except a JAL at the BIOS base.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC   = 32'h4000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] JAL_WORD = 32'h0080_006F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int          vectors = 0;
    int          errors = 0;
    logic        jal_en = 1'b0;
    logic [31:0] next_seq = RST_PC;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jal_en && (a == RST_PC)) return JAL_WORD;
        return a;
    endfunction

    // Synchronous-read IMEM; garbage when not strobed so unrequested pushes show up.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
        else         imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic sb_fill();
        logic [31:0] w;
        while (exp_q.size() < 4) begin
            w = mem_word(next_seq);
            exp_q.push_back({next_seq, w});
`ifdef IF_JAL_PREDECODE_EN
            if (w == JAL_WORD) next_seq = next_seq + 32'd8;
            else               next_seq = next_seq + 32'd4;
`else
            next_seq = next_seq + 32'd4;
`endif
        end
    endtask

    task automatic sb_restart(input logic [31:0] base);
        exp_q.delete();
        next_seq = base;
        sb_fill();
    endtask

    // Every accepted word must be the next one of the architectural stream.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_underflow: got pc %h, expected no output", out_pc);
            end else begin
                exp = exp_q.pop_front();
                if ({out_pc, out_inst} !== exp) begin
                    errors++;
                    $display("[TB] FAIL sb_word: got pc %h inst %h, expected pc %h inst %h",
                             out_pc, out_inst, exp[63:32], exp[31:0]);
                end
                sb_fill();
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", out_valid); end
        vectors++; if (out_inst !== NOP) begin errors++; $display("[TB] FAIL rst_inst: got %h expected %h", out_inst, NOP); end
        vectors++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc: got %h expected 0", out_pc); end
        vectors++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_en: got %b expected 0", imem_en); end
        next_cycle();
    endtask

    task automatic test_sequential();
        rst_n = 1'b1;
        out_ready = 1'b1;
        sb_restart(RST_PC);
        @(negedge clk);
        vectors++; if (imem_en !== 1'b1) begin errors++; $display("[TB] FAIL seq_en0: got %b expected 1", imem_en); end
        vectors++; if (imem_addr !== RST_PC) begin errors++; $display("[TB] FAIL seq_addr0: got %h expected %h", imem_addr, RST_PC); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_valid0: got %b expected 0", out_valid); end
        next_cycle();
        @(negedge clk);
        vectors++; if (imem_addr !== RST_PC + 32'd4) begin errors++; $display("[TB] FAIL seq_addr1: got %h expected %h", imem_addr, RST_PC + 32'd4); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_valid1: got %b expected 0", out_valid); end
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== RST_PC + 32'(4 * k)) begin
                errors++;
                $display("[TB] FAIL seq_out%0d: got valid %b pc %h expected valid 1 pc %h",
                         k, out_valid, out_pc, RST_PC + 32'(4 * k));
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 32'h4000_000C || imem_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall%0d: got valid %b pc %h en %b expected 1 4000000c 0",
                         k, out_valid, out_pc, imem_en);
            end
            next_cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 32'h4000_000C + 32'(4 * k)) begin
                errors++;
                $display("[TB] FAIL resume%0d: got valid %b pc %h expected valid 1 pc %h",
                         k, out_valid, out_pc, 32'h4000_000C + 32'(4 * k));
            end
            next_cycle();
        end
    endtask

    task automatic test_redirect();
        out_ready = 1'b0;
        repeat (3) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h4000_0103;
        out_ready = 1'b1;
        sb_restart(32'h4000_0100);
        @(negedge clk);
        vectors++; if (imem_en !== 1'b1) begin errors++; $display("[TB] FAIL redir_en: got %b expected 1", imem_en); end
        vectors++; if (imem_addr !== 32'h4000_0100) begin errors++; $display("[TB] FAIL redir_addr: got %h expected 40000100", imem_addr); end
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_bubble: got %b expected 0", out_valid); end
        vectors++; if (imem_addr !== 32'h4000_0104) begin errors++; $display("[TB] FAIL redir_next_addr: got %h expected 40000104", imem_addr); end
        next_cycle();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h4000_0100) begin errors++; $display("[TB] FAIL redir_first: got valid %b pc %h expected 1 40000100", out_valid, out_pc); end
        repeat (4) next_cycle();
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        sb_restart(32'h0000_0200);
        @(negedge clk);
        vectors++; if (imem_addr !== 32'h0000_0200) begin errors++; $display("[TB] FAIL b2b_addr0: got %h expected 00000200", imem_addr); end
        next_cycle();
        redirect_pc = 32'h0000_0300;
        sb_restart(32'h0000_0300);
        @(negedge clk);
        vectors++; if (imem_addr !== 32'h0000_0300) begin errors++; $display("[TB] FAIL b2b_addr1: got %h expected 00000300", imem_addr); end
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_bubble: got %b expected 0", out_valid); end
        next_cycle();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_0300) begin errors++; $display("[TB] FAIL b2b_first: got valid %b pc %h expected 1 00000300", out_valid, out_pc); end
        repeat (4) next_cycle();
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        sb_restart(32'hFFFF_FFF8);
        next_cycle();
        redirect_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        vectors++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected 00000000", imem_addr); end
        vectors++; if (out_pc !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_first: got %h expected fffffff8", out_pc); end
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_zero: got valid %b pc %h expected 1 00000000", out_valid, out_pc); end
        repeat (3) next_cycle();
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || out_inst !== NOP || out_pc !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_out: got valid %b pc %h inst %h expected 0 0 00000013", out_valid, out_pc, out_inst); end
        vectors++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_en: got %b expected 0", imem_en); end
        next_cycle();
        rst_n = 1'b1;
        sb_restart(RST_PC);
        @(negedge clk);
        vectors++; if (imem_en !== 1'b1 || imem_addr !== RST_PC) begin errors++; $display("[TB] FAIL mid_addr: got en %b addr %h expected 1 %h", imem_en, imem_addr, RST_PC); end
        next_cycle();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_bubble: got %b expected 0", out_valid); end
        next_cycle();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1 || out_pc !== RST_PC) begin errors++; $display("[TB] FAIL mid_first: got valid %b pc %h expected 1 %h", out_valid, out_pc, RST_PC); end
        repeat (3) next_cycle();
    endtask

    task automatic test_jal();
        jal_en = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = RST_PC;
        sb_restart(RST_PC);
        next_cycle();
        redirect_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        vectors++; if (out_pc !== RST_PC || out_inst !== JAL_WORD) begin errors++; $display("[TB] FAIL jal_word: got pc %h inst %h expected %h %h", out_pc, out_inst, RST_PC, JAL_WORD); end
        next_cycle();
        @(negedge clk);
`ifdef IF_JAL_PREDECODE_EN
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL jal_bubble: got %b expected 0", out_valid); end
        next_cycle();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h4000_0008) begin errors++; $display("[TB] FAIL jal_target: got valid %b pc %h expected 1 40000008", out_valid, out_pc); end
`else
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h4000_0004) begin errors++; $display("[TB] FAIL jal_seq: got valid %b pc %h expected 1 40000004", out_valid, out_pc); end
`endif
        repeat (4) next_cycle();
        jal_en = 1'b0;
    endtask

    initial begin
        $display("[TB] if_fetch_stage bench start");
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_jal();
        out_ready = 1'b0;
        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
